mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits between the processor core and the byte-lane Ram.
- Arbitrates two requesters, instruction fetch (I) and load/store (D), onto the Ram's single port.
- Translates byte, halfword and word requests into a word-aligned Ram address plus lane enables (en1h, en1l, en2h, en2l).
- Drives and releases the tristate lane buses, captures read data and returns a per-port ack or error.

Parameters:
- ADDR_W, 32, width of all address ports.
- MEM_BYTES, 1024, Ram size in bytes; any access with addr >= MEM_BYTES is an error.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch byte address; word access only.
- i_rdata  out  32  fetched word; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  qualifies i_ack: misaligned or out-of-range fetch.
- d_req  in  1  data request; held until d_ack.
- d_rw  in  1  1 = write, 0 = read.
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  write data, right-justified.
- d_rdata  out  32  read data, right-justified, zero-extended; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  qualifies d_ack: misaligned, out-of-range or reserved size.
- ram_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- ram_rw  out  1  Ram write strobe.
- ram_en1h, ram_en1l, ram_en2h, ram_en2l  out  1 each  lane enables.
- ram_data1h, ram_data1l, ram_data2h, ram_data2l  inout  8 each  lane buses.

Behaviour:
- Lane map, big-endian: byte offset 0 -> 1h, 1 -> 1l, 2 -> 2h, 3 -> 2l.
  - Byte access enables one lane.
  - Halfword at offset 0 enables 1h/1l; at offset 2 enables 2h/2l.
  - Word access enables all four lanes.
- Error conditions; an errored request never asserts any Ram enable:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - d_size=11;
  - addr >= MEM_BYTES.
- FSM states IDLE, ACCESS, DONE.
  - IDLE: samples both requests. On grant, latches port id, addr, size, rw and wdata.
    - Valid request -> ACCESS.
    - Errored request -> DONE with err set.
  - ACCESS: exactly one cycle.
    - ram_addr, ram_rw and enables driven from the latched values.
    - For writes, lane buses driven only on enabled lanes; all other lanes stay z.
    - For reads, the bus is z, and enabled lanes are captured at the posedge ending ACCESS.
    - -> DONE.
  - DONE: ack of the granted port = 1 for one cycle with rdata/err valid; all Ram enables 0, ram_rw 0, bus z. -> IDLE.
- Latency: request sampled at edge N; ack is high in the cycle after edge N+2, or after edge N+1 on error.
- Requester rules:
  - Must keep req, addr and data stable until ack.
  - Must drop req before the next IDLE sample, or the request is taken as a new one.
- Read data: unselected bytes are 0.
  - Byte result is lane byte in [7:0].
  - Halfword result is the lane pair in [15:0].
- The non-granted port waits with ack=0 and no side effect.
- Simultaneous requests: see Optional Feature.
- Reset (0), asynchronously, including mid-ACCESS:
  - FSM -> IDLE.
  - All enables, ram_rw, acks and errs -> 0; ram_addr -> 0; rdata -> 0; buses -> z.
  - Last-grant register -> I.
  - An interrupted write may leave partial Ram contents. No retry.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both req=1 in IDLE, grant the port not granted last.
  - Last-grant updates on every grant, including errored ones.
  - After reset, D wins first.
- Undefined: fixed priority, D always wins over I; the last-grant register is not built.

Test Plan:
- D word write addr 32, data AABB4455 -> ACCESS shows ram_addr=32, all enables, lanes AA/BB/44/55, d_ack 2 cycles after sample. D word read addr 32 -> d_rdata=AABB4455, d_err=0.
- D byte write addr 25, data FF -> only ram_en1l, data1l=FF, other lanes z. Byte read addr 25 -> d_rdata=000000FF.
- D halfword write addr 22, data A0A0 -> ram_addr=20, en2h/en2l only. Halfword read addr 22 -> d_rdata=0000A0A0.
- Halfword addr 17, word addr 34, size 11, and word addr 1024 -> each gives d_ack with d_err=1 one cycle after sample, no Ram enable ever asserted.
- i_req (addr 0) and d_req (read addr 32) held continuously:
  - Macro defined: grants D, I, D, I; I receives Ram[0..3].
  - Macro undefined: D granted every time.
- Reset driven to 0 during write ACCESS -> enables, ram_rw and acks 0 immediately, buses z. After release, next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response bundle between the fetch/load-store units and the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_ack;
    logic              i_err;

    logic              d_req;
    logic              d_rw;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              d_err;

    modport master (
        output i_req, i_addr, d_req, d_rw, d_size, d_addr, d_wdata,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_rw, d_size, d_addr, d_wdata,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single big-endian byte-lane Ram port.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin grant on contention
// (default: load/store always wins).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rw,
    output logic              ram_en1h,
    output logic              ram_en1l,
    output logic              ram_en2h,
    output logic              ram_en2l,
    inout  wire  [7:0]        ram_data1h,
    inout  wire  [7:0]        ram_data1l,
    inout  wire  [7:0]        ram_data2h,
    inout  wire  [7:0]        ram_data2l
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    state_t            state_nxt;

    logic              gnt_v;
    logic              gnt_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic              sel_rw;
    logic [1:0]        sel_off;
    logic              sel_err;
    logic [3:0]        sel_mask;
    logic [4:0]        sel_shift;

    logic              port_d_q;
    logic              err_q;
    logic              rw_q;
    logic [4:0]        shift_q;
    logic [31:0]       rd_q;
    logic [31:0]       wd_q;
    logic [31:0]       lanes_in;
    logic [31:0]       lane_mask;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d;

    // Remember which port won last so contention alternates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else if (state == IDLE && gnt_v) begin
            last_d <= gnt_d;
        end
    end
`endif

    // Grant selection among pending requests
    always_comb begin
        gnt_v = bus.i_req | bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
        gnt_d = bus.d_req & (~bus.i_req | ~last_d);
`else
        gnt_d = bus.d_req;
`endif
    end

    // Decode the granted request into lane mask, alignment shift and error
    always_comb begin
        sel_addr  = gnt_d ? bus.d_addr : bus.i_addr;
        sel_size  = gnt_d ? bus.d_size : 2'b10;
        sel_rw    = gnt_d & bus.d_rw;
        sel_off   = sel_addr[1:0];
        sel_err   = (sel_addr >= ADDR_W'(MEM_BYTES));
        sel_mask  = 4'b0000;
        sel_shift = 5'd0;
        case (sel_size)
            2'b00: begin
                sel_mask  = 4'b1000 >> sel_off;
                sel_shift = {~sel_off, 3'b000};
            end
            2'b01: begin
                sel_mask  = sel_off[1] ? 4'b0011 : 4'b1100;
                sel_shift = sel_off[1] ? 5'd0 : 5'd16;
                if (sel_off[0]) sel_err = 1'b1;
            end
            2'b10: begin
                sel_mask = 4'b1111;
                if (sel_off != 2'b00) sel_err = 1'b1;
            end
            default: sel_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: errored requests skip the Ram access
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_v) state_nxt = sel_err ? DONE : ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ram port registers: only non-zero for the single ACCESS cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram_addr <= '0;
            ram_rw   <= 1'b0;
            ram_en1h <= 1'b0;
            ram_en1l <= 1'b0;
            ram_en2h <= 1'b0;
            ram_en2l <= 1'b0;
            wd_q     <= '0;
        end else if (state_nxt == ACCESS) begin
            ram_addr <= {sel_addr[ADDR_W-1:2], 2'b00};
            ram_rw   <= sel_rw;
            {ram_en1h, ram_en1l, ram_en2h, ram_en2l} <= sel_mask;
            wd_q     <= bus.d_wdata << sel_shift;
        end else begin
            ram_addr <= '0;
            ram_rw   <= 1'b0;
            ram_en1h <= 1'b0;
            ram_en1l <= 1'b0;
            ram_en2h <= 1'b0;
            ram_en2l <= 1'b0;
            wd_q     <= '0;
        end
    end

    assign lanes_in  = {ram_data1h, ram_data1l, ram_data2h, ram_data2l};
    assign lane_mask = {{8{ram_en1h}}, {8{ram_en1l}}, {8{ram_en2h}}, {8{ram_en2l}}};

    // Lane buses driven only on enabled lanes of a write
    assign ram_data1h = (ram_rw && ram_en1h) ? wd_q[31:24] : 8'hzz;
    assign ram_data1l = (ram_rw && ram_en1l) ? wd_q[23:16] : 8'hzz;
    assign ram_data2h = (ram_rw && ram_en2h) ? wd_q[15:8]  : 8'hzz;
    assign ram_data2l = (ram_rw && ram_en2l) ? wd_q[7:0]   : 8'hzz;

    // Latch the grant at IDLE, capture right-justified read data at the end of ACCESS
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            port_d_q <= 1'b0;
            err_q    <= 1'b0;
            rw_q     <= 1'b0;
            shift_q  <= '0;
            rd_q     <= '0;
        end else if (state == IDLE && gnt_v) begin
            port_d_q <= gnt_d;
            err_q    <= sel_err;
            rw_q     <= sel_rw;
            shift_q  <= sel_shift;
            rd_q     <= '0;
        end else if (state == ACCESS && !rw_q) begin
            rd_q <= (lanes_in & lane_mask) >> shift_q;
        end
    end

    // Per-port completion pulse with data and error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.i_ack   <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_ack   <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= '0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.i_err <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.d_err <= 1'b0;
            if (state == DONE) begin
                if (port_d_q) begin
                    bus.d_ack   <= 1'b1;
                    bus.d_err   <= err_q;
                    bus.d_rdata <= rd_q;
                end else begin
                    bus.i_ack   <= 1'b1;
                    bus.i_err   <= err_q;
                    bus.i_rdata <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset and
// contention sequences, then random traffic against a byte-array memory model.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ram_addr;
    logic        ram_rw;
    logic        ram_en1h, ram_en1l, ram_en2h, ram_en2l;
    wire  [7:0]  ram_data1h, ram_data1l, ram_data2h, ram_data2l;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .ram_addr   (ram_addr),
        .ram_rw     (ram_rw),
        .ram_en1h   (ram_en1h),
        .ram_en1l   (ram_en1l),
        .ram_en2h   (ram_en2h),
        .ram_en2l   (ram_en2l),
        .ram_data1h (ram_data1h),
        .ram_data1l (ram_data1l),
        .ram_data2h (ram_data2h),
        .ram_data2l (ram_data2l)
    );

    always #5 clock = ~clock;

    // External byte-lane Ram
    logic [7:0] ram [1024] = '{default: 8'h00};
    logic [9:0] ra;
    assign ra = ram_addr[9:0];
    assign ram_data1h = (ram_en1h && !ram_rw) ? ram[ra]         : 8'hzz;
    assign ram_data1l = (ram_en1l && !ram_rw) ? ram[ra + 10'd1] : 8'hzz;
    assign ram_data2h = (ram_en2h && !ram_rw) ? ram[ra + 10'd2] : 8'hzz;
    assign ram_data2l = (ram_en2l && !ram_rw) ? ram[ra + 10'd3] : 8'hzz;

    always @(posedge clock) begin
        if (ram_rw) begin
            if (ram_en1h) ram[ra]         <= ram_data1h;
            if (ram_en1l) ram[ra + 10'd1] <= ram_data1l;
            if (ram_en2h) ram[ra + 10'd2] <= ram_data2h;
            if (ram_en2l) ram[ra + 10'd3] <= ram_data2l;
        end
    end

    // Reference model: memory as a plain big-endian byte array
    logic [7:0] model [1024] = '{default: 8'h00};

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (addr >= 32'd1024) return 1'b1;
        if (size == 2'b11) return 1'b1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < nbytes(size); i++) r = (r << 8) | 32'(model[addr + i]);
        return r;
    endfunction

    task automatic model_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n = nbytes(size);
        for (int i = 0; i < n; i++) model[addr + i] = wdata[(n - 1 - i) * 8 +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One request on a port; returns what was observed. lat = 0 means no ack within budget.
    task automatic do_req(input bit is_d, input logic rw, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic got_err, output logic [31:0] got_rdata, output int lat,
                          output logic [3:0] en_or, output logic [31:0] raddr,
                          output logic [31:0] lanes);
        logic [3:0] en;
        got_err = 1'b0; got_rdata = 32'd0; lat = 0; en_or = 4'd0; raddr = 32'd0; lanes = 32'd0;
        if (is_d) begin
            bus.d_rw = rw; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
        end else begin
            bus.i_addr = addr; bus.i_req = 1'b1;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            en = {ram_en1h, ram_en1l, ram_en2h, ram_en2l};
            if (en != 4'd0) begin
                en_or = en_or | en;
                raddr = ram_addr;
                if (ram_rw)
                    lanes = {ram_data1h, ram_data1l, ram_data2h, ram_data2l} &
                            {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
            end
            if (is_d ? bus.d_ack : bus.i_ack) begin
                lat       = c;
                got_err   = is_d ? bus.d_err : bus.i_err;
                got_rdata = is_d ? bus.d_rdata : bus.i_rdata;
                break;
            end
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [3:0]  en;
        logic [31:0] raddr;
        logic [31:0] lanes;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [3:0] en,
                                input logic [31:0] raddr, input logic [31:0] lanes,
                                input logic [31:0] rdata);
        vec_t v;
        v.rw = rw; v.size = size; v.addr = addr; v.wdata = wdata; v.err = err;
        v.en = en; v.raddr = raddr; v.lanes = lanes; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        vec_t        vecs [17];
        logic        g_err;
        logic [31:0] g_rd, g_ra, g_ln;
        logic [3:0]  g_en;
        int          g_lat;
        bit          seq [4];
        bit          exp_seq [4];
        int          n;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_size = 2'b00; bus.d_addr = '0; bus.d_wdata = '0;

        //           rw    size   addr     wdata         err   en       raddr    lanes         rdata
        vecs[0]  = mk(1'b1, 2'b10, 32'd32,   32'hAABB4455, 1'b0, 4'b1111, 32'd32,   32'hAABB4455, 32'h0);
        vecs[1]  = mk(1'b0, 2'b10, 32'd32,   32'h0,        1'b0, 4'b1111, 32'd32,   32'h0,        32'hAABB4455);
        vecs[2]  = mk(1'b1, 2'b00, 32'd25,   32'h000000FF, 1'b0, 4'b0100, 32'd24,   32'h00FF0000, 32'h0);
        vecs[3]  = mk(1'b0, 2'b00, 32'd25,   32'h0,        1'b0, 4'b0100, 32'd24,   32'h0,        32'h000000FF);
        vecs[4]  = mk(1'b1, 2'b01, 32'd22,   32'h0000A0A0, 1'b0, 4'b0011, 32'd20,   32'h0000A0A0, 32'h0);
        vecs[5]  = mk(1'b0, 2'b01, 32'd22,   32'h0,        1'b0, 4'b0011, 32'd20,   32'h0,        32'h0000A0A0);
        vecs[6]  = mk(1'b0, 2'b01, 32'd17,   32'h0,        1'b1, 4'b0000, 32'd0,    32'h0,        32'h0);
        vecs[7]  = mk(1'b0, 2'b10, 32'd34,   32'h0,        1'b1, 4'b0000, 32'd0,    32'h0,        32'h0);
        vecs[8]  = mk(1'b0, 2'b11, 32'd8,    32'h0,        1'b1, 4'b0000, 32'd0,    32'h0,        32'h0);
        vecs[9]  = mk(1'b0, 2'b10, 32'd1024, 32'h0,        1'b1, 4'b0000, 32'd0,    32'h0,        32'h0);
        vecs[10] = mk(1'b1, 2'b01, 32'd1024, 32'h00001234, 1'b1, 4'b0000, 32'd0,    32'h0,        32'h0);
        vecs[11] = mk(1'b1, 2'b00, 32'd1023, 32'h0000005A, 1'b0, 4'b0001, 32'd1020, 32'h0000005A, 32'h0);
        vecs[12] = mk(1'b0, 2'b10, 32'd1020, 32'h0,        1'b0, 4'b1111, 32'd1020, 32'h0,        32'h0000005A);
        vecs[13] = mk(1'b0, 2'b10, 32'd24,   32'h0,        1'b0, 4'b1111, 32'd24,   32'h0,        32'h00FF0000);
        vecs[14] = mk(1'b0, 2'b10, 32'd20,   32'h0,        1'b0, 4'b1111, 32'd20,   32'h0,        32'h0000A0A0);
        vecs[15] = mk(1'b1, 2'b01, 32'd8,    32'h0000BEEF, 1'b0, 4'b1100, 32'd8,    32'hBEEF0000, 32'h0);
        vecs[16] = mk(1'b0, 2'b00, 32'd9,    32'h0,        1'b0, 4'b0100, 32'd8,    32'h0,        32'h000000EF);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_enables", 32'({ram_en1h, ram_en1l, ram_en2h, ram_en2l, ram_rw}), 32'd0);
        chk("rst_acks", 32'({bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed vector table on the D port
        for (int i = 0; i < 17; i++) begin
            do_req(1'b1, vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                   g_err, g_rd, g_lat, g_en, g_ra, g_ln);
            chk($sformatf("vec%0d_latency", i), 32'(g_lat), vecs[i].err ? 32'd2 : 32'd3);
            chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_enables", i), 32'(g_en), 32'(vecs[i].en));
            if (!vecs[i].err) chk($sformatf("vec%0d_ram_addr", i), g_ra, vecs[i].raddr);
            if (!vecs[i].err && vecs[i].rw) chk($sformatf("vec%0d_lanes", i), g_ln, vecs[i].lanes);
            if (!vecs[i].err && !vecs[i].rw) chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].rdata);
            if (!vecs[i].err && vecs[i].rw) model_write(vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // I-port fetches: valid, misaligned, out of range
        do_req(1'b0, 1'b0, 2'b10, 32'd32, 32'd0, g_err, g_rd, g_lat, g_en, g_ra, g_ln);
        chk("ifetch32_rdata", g_rd, 32'hAABB4455);
        chk("ifetch32_err", 32'(g_err), 32'd0);
        do_req(1'b0, 1'b0, 2'b10, 32'd2, 32'd0, g_err, g_rd, g_lat, g_en, g_ra, g_ln);
        chk("ifetch2_err", 32'(g_err), 32'd1);
        chk("ifetch2_enables", 32'(g_en), 32'd0);
        do_req(1'b0, 1'b0, 2'b10, 32'd1024, 32'd0, g_err, g_rd, g_lat, g_en, g_ra, g_ln);
        chk("ifetch1024_err", 32'(g_err), 32'd1);
        chk("ifetch1024_latency", 32'(g_lat), 32'd2);

        // Seed Ram[0..3] for the contention test
        do_req(1'b1, 1'b1, 2'b10, 32'd0, 32'h11223344, g_err, g_rd, g_lat, g_en, g_ra, g_ln);
        model_write(2'b10, 32'd0, 32'h11223344);

        // Reset asserted in the middle of a write ACCESS
        bus.d_rw = 1'b1; bus.d_size = 2'b10; bus.d_addr = 32'd40; bus.d_wdata = 32'hDEADBEEF;
        bus.d_req = 1'b1;
        @(posedge clock); #1;
        chk("rstmid_access_en", 32'({ram_en1h, ram_en1l, ram_en2h, ram_en2l, ram_rw}), 32'h1F);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_enables", 32'({ram_en1h, ram_en1l, ram_en2h, ram_en2l, ram_rw}), 32'd0);
        chk("rstmid_acks", 32'({bus.i_ack, bus.d_ack}), 32'd0);
        chk("rstmid_ram_addr", ram_addr, 32'd0);
        bus.d_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Contention: both requests held continuously
        bus.i_addr = 32'd0; bus.i_req = 1'b1;
        bus.d_rw = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'd32; bus.d_req = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge clock); #1;
            chk("arb_single_ack", 32'(bus.i_ack & bus.d_ack), 32'd0);
            if (bus.d_ack) begin
                seq[n] = 1'b1;
                chk("arb_d_rdata", bus.d_rdata, 32'hAABB4455);
                n++;
            end else if (bus.i_ack) begin
                seq[n] = 1'b0;
                chk("arb_i_rdata", bus.i_rdata, 32'h11223344);
                n++;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("arb_ack_count", 32'(n), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 4; k++)
            if (k < n) chk($sformatf("arb_grant%0d_is_d", k), 32'(seq[k]), 32'(exp_seq[k]));

        // Refresh the word whose write was interrupted
        do_req(1'b1, 1'b1, 2'b10, 32'd40, 32'h0BADF00D, g_err, g_rd, g_lat, g_en, g_ra, g_ln);
        model_write(2'b10, 32'd40, 32'h0BADF00D);
        chk("post_rst_write_latency", 32'(g_lat), 32'd3);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            bit          is_d  = ($urandom_range(0, 3) != 0);
            logic        rw    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            logic [1:0]  size  = is_d ? 2'($urandom_range(0, 3)) : 2'b10;
            logic [31:0] addr  = ($urandom_range(0, 15) == 0) ? 32'(1000 + $urandom_range(0, 60))
                                                              : 32'($urandom_range(0, 1023));
            logic [31:0] wdata = $urandom;
            logic        e_err = model_err(size, addr);
            logic [31:0] e_rd  = e_err ? 32'd0 : model_read(size, addr);
            do_req(is_d, rw, size, addr, wdata, g_err, g_rd, g_lat, g_en, g_ra, g_ln);
            chk($sformatf("rnd%0d_latency", t), 32'(g_lat), e_err ? 32'd2 : 32'd3);
            chk($sformatf("rnd%0d_err", t), 32'(g_err), 32'(e_err));
            if (e_err) chk($sformatf("rnd%0d_no_enable", t), 32'(g_en), 32'd0);
            if (!e_err && !rw) chk($sformatf("rnd%0d_rdata", t), g_rd, e_rd);
            if (!e_err && rw) model_write(size, addr, wdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
